// File: rtl/core_pkg.sv
// Definitions shared by the fetch, decode and hazard logic of the core.
// Covers address width, the canonical NOP and the fetch FSM state encoding.
package core_pkg;

  localparam int          ADDR_W    = 11;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return lsbs == 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds by default, loads a new instruction on load,
// and on flush clears valid and substitutes the NOP (flush wins over load).
module if_id_reg #(
  parameter int          ADDR_W    = core_pkg::ADDR_W,
  parameter logic [31:0] NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              load,
  input  logic [31:0]       in_instr,
  input  logic [ADDR_W-1:0] in_pc,
  output logic              out_valid,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  logic              valid_q, valid_d;
  logic [31:0]       instr_q, instr_d;
  logic [ADDR_W-1:0] pc_q, pc_d;

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    if (flush) begin
      // if_pc keeps its old value; consumers must ignore it while invalid
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = in_instr;
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_instr = instr_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the instruction memory address,
// and applies redirects, stalls and misaligned-target fault halting.
module fetch_unit #(
  parameter int                         ADDR_W    = core_pkg::ADDR_W,
  parameter logic [core_pkg::ADDR_W-1:0] RESET_PC = '0,
  parameter logic [31:0]                NOP_INSTR = core_pkg::NOP_INSTR
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              if_valid,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              fault,
  output logic [ADDR_W-1:0] fault_addr,
  output logic [31:0]       fetch_count
);

  import core_pkg::*;

  // Every fetched PC is a RESET_PC + 4k or an aligned redirect, so alignment holds by construction
  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("fetch_unit: RESET_PC must be word-aligned");
  end

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              fault_q, fault_d;
  logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
  logic [31:0]       fetch_count_q, fetch_count_d;
  logic              capture;
  logic              flush;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fault_d       = fault_q;
    fault_addr_d  = fault_addr_q;
    fetch_count_d = fetch_count_q;
    capture       = 1'b0;
    flush         = 1'b0;
    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redirect_valid) begin
          flush = 1'b1;
          if (!is_word_aligned(redirect_target[1:0])) begin
            state_d      = HALT;
            fault_d      = 1'b1;
            fault_addr_d = redirect_target;
          end else begin
            pc_d = redirect_target;
          end
        end else if (!stall) begin
          capture       = 1'b1;
          pc_d          = pc_q + ADDR_W'(4);
          fetch_count_d = fetch_count_q + 32'd1;
        end
      end
      HALT: state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      fault_q       <= 1'b0;
      fault_addr_q  <= '0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fault_q       <= fault_d;
      fault_addr_q  <= fault_addr_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(
    .ADDR_W   (ADDR_W),
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .load     (capture),
    .in_instr (imem_data),
    .in_pc    (pc_q),
    .out_valid(if_valid),
    .out_instr(if_instr),
    .out_pc   (if_pc)
  );

  assign imem_addr   = pc_q;
  assign fault       = fault_q;
  assign fault_addr  = fault_addr_q;
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a behavioural model pushes the expected
// post-edge outputs into a queue; each is popped and compared after the edge.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        redirect_valid;
  logic [10:0] redirect_target;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [10:0] if_pc;
  logic        fault;
  logic [10:0] fault_addr;
  logic [31:0] fetch_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem_b [0:2047];

  typedef struct {
    logic [10:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [10:0] ipc;
    logic        flt;
    logic [10:0] faddr;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  // model state: 0 boot, 1 run, 2 halt
  int          m_state;
  logic [10:0] m_pc;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [10:0] m_ipc;
  logic        m_fault;
  logic [10:0] m_faddr;
  logic [31:0] m_cnt;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fault          (fault),
    .fault_addr     (fault_addr),
    .fetch_count    (fetch_count)
  );

  always #5 clk = ~clk;

  // big-endian byte memory, combinational read
  always_comb begin
    imem_data = {mem_b[imem_addr], mem_b[imem_addr + 11'd1],
                 mem_b[imem_addr + 11'd2], mem_b[imem_addr + 11'd3]};
  end

  function automatic logic [31:0] rd_word(input logic [10:0] a);
    return {mem_b[a], mem_b[a + 11'd1], mem_b[a + 11'd2], mem_b[a + 11'd3]};
  endfunction

  task automatic set_word(input logic [10:0] a, input logic [31:0] w);
    mem_b[a]         = w[31:24];
    mem_b[a + 11'd1] = w[23:16];
    mem_b[a + 11'd2] = w[15:8];
    mem_b[a + 11'd3] = w[7:0];
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic s, input logic rv,
                     input logic [10:0] rt, input string tag);
    exp_t e;
    rst             = r;
    stall           = s;
    redirect_valid  = rv;
    redirect_target = rt;
    if (r) begin
      m_state = 0; m_pc = 11'h000; m_valid = 1'b0; m_instr = NOP; m_ipc = 11'h000;
      m_fault = 1'b0; m_faddr = 11'h000; m_cnt = 32'd0;
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1) begin
      if (rv && rt[1:0] != 2'b00) begin
        m_state = 2; m_fault = 1'b1; m_faddr = rt; m_valid = 1'b0; m_instr = NOP;
      end else if (rv) begin
        m_pc = rt; m_valid = 1'b0; m_instr = NOP;
      end else if (!s) begin
        m_instr = rd_word(m_pc); m_ipc = m_pc; m_valid = 1'b1;
        m_pc = m_pc + 11'd4; m_cnt = m_cnt + 32'd1;
      end
    end
    e.addr = m_pc; e.valid = m_valid; e.instr = m_instr; e.ipc = m_ipc;
    e.flt = m_fault; e.faddr = m_faddr; e.cnt = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    $display("txn %-10s rst=%b stall=%b rv=%b rt=%h -> addr=%h v=%b instr=%h ipc=%h flt=%b cnt=%0d",
             tag, r, s, rv, rt, imem_addr, if_valid, if_instr, if_pc, fault, fetch_count);
    chk({tag, ".addr"},  32'(imem_addr),  32'(e.addr));
    chk({tag, ".valid"}, 32'(if_valid),   32'(e.valid));
    chk({tag, ".instr"}, if_instr,        e.instr);
    chk({tag, ".ipc"},   32'(if_pc),      32'(e.ipc));
    chk({tag, ".fault"}, 32'(fault),      32'(e.flt));
    chk({tag, ".faddr"}, 32'(fault_addr), 32'(e.faddr));
    chk({tag, ".cnt"},   fetch_count,     e.cnt);
  endtask

  initial begin
    logic        rs;
    logic        rrv;
    logic [10:0] rrt;
    for (int i = 0; i < 512; i++) set_word(11'(i * 4), 32'hC000_0000 + 32'(i * 4));
    set_word(11'h000, 32'h0000_0013);
    set_word(11'h004, 32'h0050_0093);
    set_word(11'h008, 32'h00A0_0113);
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = '0;

    cyc(1, 0, 0, 11'h000, "reset");
    cyc(1, 0, 0, 11'h000, "reset");
    chk("rst.valid", 32'(if_valid), 32'd0);
    chk("rst.instr", if_instr, NOP);
    cyc(0, 0, 0, 11'h000, "boot");
    chk("boot.novalid", 32'(if_valid), 32'd0);
    cyc(0, 0, 0, 11'h000, "run0");
    chk("first.instr", if_instr, 32'h0000_0013);
    cyc(0, 0, 0, 11'h000, "run4");
    chk("second.instr", if_instr, 32'h0050_0093);
    for (int i = 0; i < 3; i++) cyc(0, 1, 0, 11'h000, "stall");
    chk("stall.addr", 32'(imem_addr), 32'h008);
    cyc(0, 0, 0, 11'h000, "resume");
    chk("resume.instr", if_instr, 32'h00A0_0113);
    chk("count3", fetch_count, 32'd3);
    cyc(0, 0, 0, 11'h000, "run");
    cyc(0, 0, 0, 11'h000, "run");

    cyc(0, 1, 1, 11'h100, "redir_stl");
    chk("redir.pc", 32'(imem_addr), 32'h100);
    cyc(0, 1, 0, 11'h000, "bubble_stl");
    chk("bubble.valid", 32'(if_valid), 32'd0);
    cyc(0, 0, 0, 11'h000, "tgt");
    chk("tgt.pc", 32'(if_pc), 32'h100);
    cyc(0, 0, 0, 11'h000, "run");

    cyc(0, 0, 1, 11'h7FC, "redir_wrap");
    cyc(0, 0, 0, 11'h000, "wrap0");
    chk("wrap.pc7fc", 32'(if_pc), 32'h7FC);
    cyc(0, 0, 0, 11'h000, "wrap1");
    chk("wrap.pc000", 32'(if_pc), 32'h000);
    chk("wrap.nofault", 32'(fault), 32'd0);

    cyc(0, 0, 1, 11'h03C, "redir3c");
    cyc(0, 0, 0, 11'h000, "run");
    cyc(1, 0, 1, 11'h080, "rst_redir");
    chk("rstwin.pc", 32'(imem_addr), 32'h000);
    chk("rstwin.cnt", fetch_count, 32'd0);
    cyc(0, 0, 0, 11'h000, "boot");
    cyc(0, 0, 0, 11'h000, "run");
    cyc(0, 0, 0, 11'h000, "run");

    for (int i = 0; i < 24; i++) begin
      rs  = ($urandom_range(0, 3) == 0);
      rrv = ($urandom_range(0, 5) == 0);
      rrt = 11'({9'($urandom_range(0, 511)), 2'b00});
      cyc(0, rs, rrv, rrt, "rand");
    end

    cyc(0, 0, 1, 11'h102, "misalign");
    chk("mis.fault", 32'(fault), 32'd1);
    chk("mis.faddr", 32'(fault_addr), 32'h102);
    for (int i = 0; i < 10; i++) begin
      rrt = 11'({9'($urandom_range(0, 511)), 2'b00});
      cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rrt, "halt");
    end
    cyc(1, 0, 0, 11'h000, "reset");
    chk("clr.fault", 32'(fault), 32'd0);
    chk("clr.pc", 32'(imem_addr), 32'h000);
    cyc(0, 0, 0, 11'h000, "boot");
    cyc(0, 0, 0, 11'h000, "run");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
